// File: rtl/cipher_sub_pkg.sv
// cipher_sub_pkg: shared constants and types for the PASTA decryption-side
// keystream subtraction stage.
//   PASTA_S  : lanes (field elements) per block
//   BITLEN   : bits per lane
//   MODULUS  : prime field modulus p (< 2**BITLEN)
//   LANES    : lanes processed per clock; PASTA_S must be a multiple of LANES
package cipher_sub_pkg;

    localparam int PASTA_S  = 32;
    localparam int BITLEN   = 17;
    localparam int MODULUS  = 65537;
    localparam int LANES    = 4;

    localparam int N_GROUPS = PASTA_S / LANES;
    localparam int CNT_W    = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;
    localparam int VEC_W    = PASTA_S * BITLEN;

    typedef logic [BITLEN-1:0] lane_t;
    typedef logic [VEC_W-1:0]  vec_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam lane_t MOD_L    = lane_t'(MODULUS);
    localparam cnt_t  LAST_GRP = cnt_t'(N_GROUPS - 1);

endpackage

// File: rtl/cipher_sub_if.sv
// cipher_sub_if: operand/result bundle of the subtraction stage.
//   start     : start request (sampled on rising clk)
//   ct        : ciphertext, lane i at [i*BITLEN +: BITLEN]
//   ks        : keystream block, same lane layout
//   pt        : recovered plaintext
//   finish    : one-cycle pulse, pt complete
//   busy      : operation in progress (RUN or DONE)
//   range_err : some captured lane was >= MODULUS; valid with finish
// master drives the request side, slave is the stage itself.
interface cipher_sub_if;
    import cipher_sub_pkg::*;

    logic start;
    vec_t ct;
    vec_t ks;
    vec_t pt;
    logic finish;
    logic busy;
    logic range_err;

    modport master (
        output start, ct, ks,
        input  pt, finish, busy, range_err
    );

    modport slave (
        input  start, ct, ks,
        output pt, finish, busy, range_err
    );

endinterface

// File: rtl/cipher_sub_mod_sub_lane.sv
// mod_sub_lane: combinational single-lane (a - b) mod p.
//   a, b      : lane operands (BITLEN bits, unsigned)
//   d         : a - b, plus one MODULUS correction when a < b, truncated
//   range_err : either operand is outside [0, MODULUS)
module mod_sub_lane
    import cipher_sub_pkg::*;
(
    input  lane_t a,
    input  lane_t b,
    output lane_t d,
    output logic  range_err
);

    lane_t raw;

    // The wrap of raw on borrow plus the wrap of the correction cancel
    // modulo 2**BITLEN, so the truncated sum is the field result for
    // in-range operands. Out-of-range operands get exactly one correction.
    assign raw       = a - b;
    assign d         = (a < b) ? lane_t'(raw + MOD_L) : raw;
    assign range_err = (a >= MOD_L) || (b >= MOD_L);

endmodule

// File: rtl/cipher_sub.sv
// cipher_sub: PASTA decryption-side keystream subtraction, PT = (CT - KS) mod p.
// Captures CT/KS on the accepting edge, then writes LANES lanes per clock
// into the plaintext register, one lane group per edge.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : cipher_sub_if.slave (start/ct/ks in, pt/finish/busy/range_err out)
//
//   state   | meaning
//   IDLE    | waiting for start
//   RUN     | writing lane group cnt each edge
//   DONE    | finish pulse; start accepted here like IDLE
module cipher_sub
    import cipher_sub_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    cipher_sub_if.slave  bus
);

    state_t state;
    state_t state_nxt;
    cnt_t   cnt;
    vec_t   ct_q;
    vec_t   ks_q;
    vec_t   pt_q;
    logic   range_q;
    logic   accept;
    logic   finish_c;
    logic   busy_c;

    lane_t             grp_a [LANES];
    lane_t             grp_b [LANES];
    lane_t             grp_d [LANES];
    logic [LANES-1:0]  grp_err;

    assign accept = bus.start && ((state == ST_IDLE) || (state == ST_DONE));

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (bus.start) state_nxt = ST_RUN;
            ST_RUN:  if (cnt == LAST_GRP) state_nxt = ST_DONE;
            ST_DONE: state_nxt = bus.start ? ST_RUN : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // state-decoded outputs
    always_comb begin
        finish_c = 1'b0;
        busy_c   = 1'b0;
        case (state)
            ST_RUN:  busy_c = 1'b1;
            ST_DONE: begin
                busy_c   = 1'b1;
                finish_c = 1'b1;
            end
            default: begin
                finish_c = 1'b0;
                busy_c   = 1'b0;
            end
        endcase
    end

    // cnt-indexed group mux over the capture registers
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign grp_a[l] = ct_q[(int'(cnt) * LANES + l) * BITLEN +: BITLEN];
        assign grp_b[l] = ks_q[(int'(cnt) * LANES + l) * BITLEN +: BITLEN];

        mod_sub_lane u_lane (
            .a         (grp_a[l]),
            .b         (grp_b[l]),
            .d         (grp_d[l]),
            .range_err (grp_err[l])
        );
    end

    // capture, group write-back and sticky range flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            ct_q    <= '0;
            ks_q    <= '0;
            pt_q    <= '0;
            range_q <= 1'b0;
        end else if (accept) begin
            cnt     <= '0;
            ct_q    <= bus.ct;
            ks_q    <= bus.ks;
            pt_q    <= '0;
            range_q <= 1'b0;
        end else if (state == ST_RUN) begin
            for (int l = 0; l < LANES; l++) begin
                pt_q[(int'(cnt) * LANES + l) * BITLEN +: BITLEN] <= grp_d[l];
            end
            range_q <= range_q | (|grp_err);
            if (cnt != LAST_GRP) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign bus.pt        = pt_q;
    assign bus.finish    = finish_c;
    assign bus.busy      = busy_c;
    assign bus.range_err = range_q;

endmodule

// File: tb/tb_cipher_sub.sv
module tb_cipher_sub;
    import cipher_sub_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    cipher_sub_if bus ();

    cipher_sub dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    vec_t ct_v;
    vec_t ks_v;
    vec_t exp_v;
    vec_t exp_ok;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input vec_t obs, input vec_t exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic scramble_inputs();
        for (int i = 0; i < PASTA_S; i++) begin
            bus.ct[i*BITLEN +: BITLEN] = lane_t'($urandom_range(0, 131071));
            bus.ks[i*BITLEN +: BITLEN] = lane_t'($urandom_range(0, 131071));
        end
    endtask

    // One full operation from the current ct_v/ks_v; checks clear-on-accept,
    // latency, result, range flag and the return to idle.
    task automatic run_op(input string tag, input vec_t exp_pt, input logic exp_err,
                          input bit scramble);
        int lat;
        bit seen;
        bus.ct    = ct_v;
        bus.ks    = ks_v;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check({tag, "_busy_acc"}, vec_t'(bus.busy), vec_t'(1));
        check({tag, "_pt_clr"}, bus.pt, '0);
        check({tag, "_err_clr"}, vec_t'(bus.range_err), vec_t'(0));
        lat  = 0;
        seen = 0;
        for (int k = 1; k <= 30 && !seen; k++) begin
            if (scramble) scramble_inputs();
            tick();
            if (bus.finish) begin
                seen = 1;
                lat  = k;
            end
        end
        check({tag, "_latency"}, vec_t'(lat), vec_t'(8));
        check({tag, "_pt"}, bus.pt, exp_pt);
        check({tag, "_range_err"}, vec_t'(bus.range_err), vec_t'(exp_err));
        tick();
        check({tag, "_fin_pulse"}, vec_t'(bus.finish), vec_t'(0));
        check({tag, "_idle"}, vec_t'(bus.busy), vec_t'(0));
        check({tag, "_pt_hold"}, bus.pt, exp_pt);
    endtask

    initial begin
        int first_fin;
        int second_fin;
        int fin_cnt;
        bit busy_all;
        bit seen;
        int c;
        int k;

        bus.start = 1'b0;
        bus.ct    = '0;
        bus.ks    = '0;

        // reset state
        #3;
        check("rst_pt", bus.pt, '0);
        check("rst_finish", vec_t'(bus.finish), vec_t'(0));
        check("rst_busy", vec_t'(bus.busy), vec_t'(0));
        check("rst_err", vec_t'(bus.range_err), vec_t'(0));
        #20;
        rst = 1'b0;
        tick();

        // 1: every lane 5 - 3 = 2
        for (int i = 0; i < PASTA_S; i++) begin
            ct_v[i*BITLEN +: BITLEN] = 17'd5;
            ks_v[i*BITLEN +: BITLEN] = 17'd3;
            exp_ok[i*BITLEN +: BITLEN] = 17'd2;
        end
        run_op("t1", exp_ok, 1'b0, 1'b0);

        // 2: borrow and boundary lanes
        ct_v  = '0;
        ks_v  = '0;
        exp_v = '0;
        ct_v[0*BITLEN +: BITLEN]  = 17'd3;
        ks_v[0*BITLEN +: BITLEN]  = 17'd5;
        exp_v[0*BITLEN +: BITLEN] = 17'd65535;
        ct_v[31*BITLEN +: BITLEN]  = 17'd0;
        ks_v[31*BITLEN +: BITLEN]  = 17'd65536;
        exp_v[31*BITLEN +: BITLEN] = 17'd1;
        ct_v[7*BITLEN +: BITLEN]  = 17'd65536;
        ks_v[7*BITLEN +: BITLEN]  = 17'd65536;
        exp_v[7*BITLEN +: BITLEN] = 17'd0;
        run_op("t2", exp_v, 1'b0, 1'b0);

        // 3: start held for 20 edges -> back-to-back ops, finish seen
        //    8 and 17 edges after the first accepting edge
        for (int i = 0; i < PASTA_S; i++) begin
            ct_v[i*BITLEN +: BITLEN] = 17'd5;
            ks_v[i*BITLEN +: BITLEN] = 17'd3;
        end
        bus.ct    = ct_v;
        bus.ks    = ks_v;
        bus.start = 1'b1;
        tick();
        first_fin  = 0;
        second_fin = 0;
        fin_cnt    = 0;
        busy_all   = 1;
        for (int j = 1; j <= 19; j++) begin
            tick();
            if (!bus.busy) busy_all = 0;
            if (bus.finish) begin
                fin_cnt++;
                if (fin_cnt == 1) first_fin = j;
                if (fin_cnt == 2) begin
                    second_fin = j;
                    check("t3_pt2", bus.pt, exp_ok);
                end
            end
        end
        bus.start = 1'b0;
        check("t3_fin_count", vec_t'(fin_cnt), vec_t'(2));
        check("t3_first_fin", vec_t'(first_fin), vec_t'(8));
        check("t3_second_fin", vec_t'(second_fin), vec_t'(17));
        check("t3_no_gap", vec_t'(busy_all), vec_t'(1));
        seen = 0;
        for (int j = 0; j < 20 && !seen; j++) begin
            tick();
            if (bus.finish) seen = 1;
        end
        check("t3_third_fin", vec_t'(seen), vec_t'(1));
        check("t3_pt3", bus.pt, exp_ok);
        tick();

        // 4: random in-range operands, inputs scrambled after capture
        for (int i = 0; i < PASTA_S; i++) begin
            c = $urandom_range(0, MODULUS - 1);
            k = $urandom_range(0, MODULUS - 1);
            ct_v[i*BITLEN +: BITLEN]  = lane_t'(c);
            ks_v[i*BITLEN +: BITLEN]  = lane_t'(k);
            exp_v[i*BITLEN +: BITLEN] = lane_t'((c + MODULUS - k) % MODULUS);
        end
        run_op("t4", exp_v, 1'b0, 1'b1);

        // 5: out-of-range lane 12, then a clean op clears the flag
        ct_v  = '0;
        ks_v  = '0;
        exp_v = '0;
        ct_v[12*BITLEN +: BITLEN]  = 17'd65537;
        exp_v[12*BITLEN +: BITLEN] = 17'd65537;
        run_op("t5", exp_v, 1'b1, 1'b0);
        for (int i = 0; i < PASTA_S; i++) begin
            ct_v[i*BITLEN +: BITLEN] = 17'd5;
            ks_v[i*BITLEN +: BITLEN] = 17'd3;
        end
        run_op("t5_clean", exp_ok, 1'b0, 1'b0);

        // 6: async reset at cnt=3, then a normal op
        bus.ct    = ct_v;
        bus.ks    = ks_v;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("t6_pt", bus.pt, '0);
        check("t6_busy", vec_t'(bus.busy), vec_t'(0));
        check("t6_finish", vec_t'(bus.finish), vec_t'(0));
        check("t6_err", vec_t'(bus.range_err), vec_t'(0));
        #15;
        rst = 1'b0;
        tick();
        fin_cnt = 0;
        for (int j = 0; j < 12; j++) begin
            tick();
            if (bus.finish) fin_cnt++;
        end
        check("t6_no_finish", vec_t'(fin_cnt), vec_t'(0));
        check("t6_pt_idle", bus.pt, '0);
        run_op("t6_after", exp_ok, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
